data_sram_like_slave: RTL and testbench
=======================================

// Module: data_sram_like_slave
// PURPOSE
//  Responder end of the CPU data-side SRAM-like bus (req/addr_ok/data_ok).
//  Accepts load/store requests from the MEM stage, queues up to DEPTH in order,
//  and completes each after a fixed latency against an internal word RAM.
//  Used as the data memory model/bridge behind the 5-stage pipeline.
// PARAMETERS
//  ADDR_W   10  word-address bits; RAM holds 2**ADDR_W 32-bit words
//  LATENCY  2   cycles from handshake to data_ok (>=1)
//  DEPTH    2   max outstanding requests (power of 2, >=1)
// PORTS
//  clk           in   1   clock, all state on rising edge
//  resetn        in   1   synchronous reset, active-low
//  data_req      in   1   request valid
//  data_wr       in   1   1=store, 0=load
//  data_size     in   2   0=byte 1=half 2=word (informational; wstrb governs writes)
//  data_wstrb    in   4   byte enables for stores
//  data_addr     in   32  byte address; bits [ADDR_W+1:2] index RAM
//  data_wdata    in   32  store data, already lane-aligned by initiator
//  stall         in   1   test backpressure: blocks accept and response
//  data_addr_ok  out  1   request accepted this cycle when data_req also high
//  data_rdata    out  32  full read word, valid only with data_ok
//  data_data_ok  out  1   one-cycle completion pulse, one per accepted request
// BEHAVIOUR
//  - Reset (resetn=0 at edge): queue emptied, counters cleared; RAM contents kept.
//    While resetn=0: addr_ok=0, data_ok=0, rdata=0 (combinationally gated).
//  - Handshake: request accepted at edge where data_req && data_addr_ok.
//    data_addr_ok = resetn && !stall && (count < DEPTH); no same-cycle bypass:
//    stays 0 when full even if head completes that cycle.
//  - Entry stores wr, wstrb, word addr, wdata, countdown loaded with LATENCY-1.
//    Every entry's countdown decrements each cycle, saturating at 0.
//  - Head completes in any cycle where head valid && countdown==0 && !stall:
//    data_ok=1; load -> rdata = RAM[head addr] (combinational read); store ->
//    rdata=0, RAM bytes with wstrb[i]=1 updated at that cycle's closing edge.
//  - Latency: handshake in cycle 0, empty queue -> data_ok in cycle LATENCY.
//    Queued entries: data_ok >= cycle after previous data_ok and >= own cycle+LATENCY.
//  - Strict in-order completion; max one data_ok per cycle.
//  - Occupancy: count += accept - complete; both in one cycle -> unchanged.
//    Pointers are log2(DEPTH) bits, wrap modulo DEPTH.
//  - RAW ordering: a load queued behind a store to same word returns new data.
//  - Addr bits above ADDR_W+1 ignored (aliasing); low 2 bits ignored; no
//    alignment check (initiator raises AdEL/AdES).
//  - stall high: no accept, head held at countdown 0, no data_ok; resumes on release.
//  - Reset mid-operation: outstanding requests dropped without data_ok;
//    pending stores not written.
//  - data_rdata = 0 whenever data_ok=0.
// TESTING
//  1 Reset, RAM[3]=0x11223344; lw addr 0x0C at cycle 0 -> data_ok only in
//    cycle 2, rdata 0x11223344; addr_ok high in cycle 0.
//  2 sb addr 0x0D wstrb 0010 wdata 0x0000AB00, then lw 0x0C back-to-back ->
//    two data_ok pulses in consecutive cycles, load returns 0x1122AB44.
//  3 Hold data_req 4 cycles with DEPTH=2 -> addr_ok low after 2 accepts until
//    first data_ok; exactly 4 data_ok pulses in order.
//  4 stall=1 during head countdown -> no data_ok while stalled; data_ok in cycle
//    after stall drops; addr_ok=0 throughout stall.
//  5 resetn=0 with 2 stores outstanding -> no data_ok, target RAM words unchanged,
//    addr_ok=1 first cycle after reset release.
//  6 Addresses 0x0000_1000 and 0x0000_0000 (ADDR_W=10) alias: sw to one,
//    lw from other returns stored value.

Source files
------------

// File: rtl/data_sram_like_slave.sv
// Responder end of the CPU data-side SRAM-like bus: in-order request queue with
// fixed completion latency in front of an internal byte-writable word RAM.
module data_sram_like_slave #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic        stall,
    output logic        data_addr_ok,
    output logic [31:0] data_rdata,
    output logic        data_data_ok
);

    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int CDW  = $clog2(LATENCY + 1);

    localparam logic [CNTW-1:0] FULL    = CNTW'(DEPTH);
    localparam logic [PW-1:0]   LAST    = PW'(DEPTH - 1);
    localparam logic [CDW-1:0]  CD_INIT = CDW'(LATENCY - 1);

    logic              r_wr    [DEPTH];
    logic [3:0]        r_wstrb [DEPTH];
    logic [ADDR_W-1:0] r_waddr [DEPTH];
    logic [31:0]       r_wdata [DEPTH];
    logic [CDW-1:0]    r_cd    [DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CNTW-1:0]   r_count;
    logic [31:0]       r_mem   [2**ADDR_W];

    logic              w_accept;
    logic              w_complete;
    logic              w_unused;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    // Occupancy is checked before this cycle's completion: no full-queue bypass.
    assign data_addr_ok = resetn && !stall && (r_count < FULL);
    assign w_accept     = data_req && data_addr_ok;
    assign w_complete   = resetn && !stall && (r_count != '0) && (r_cd[r_head] == '0);
    assign data_data_ok = w_complete;
    assign data_rdata   = (w_complete && !r_wr[r_head]) ? r_mem[r_waddr[r_head]] : '0;

    // Size and the ignored address bits only feed this reduction.
    assign w_unused = ^{data_size, data_addr[31:ADDR_W+2], data_addr[1:0]};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (r_cd[i] != '0) r_cd[i] <= r_cd[i] - CDW'(1);
            end
            if (w_accept) begin
                r_wr[r_tail]    <= data_wr;
                r_wstrb[r_tail] <= data_wstrb;
                r_waddr[r_tail] <= data_addr[ADDR_W+1:2];
                r_wdata[r_tail] <= data_wdata;
                r_cd[r_tail]    <= CD_INIT;
                r_tail          <= f_next(r_tail);
            end
            if (w_complete) r_head <= f_next(r_head);
            case ({w_accept, w_complete})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // RAM survives reset; a store lands only at the edge closing its data_ok cycle.
    always_ff @(posedge clk) begin
        if (w_complete && r_wr[r_head]) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (r_wstrb[r_head][b])
                    r_mem[r_waddr[r_head]][8*b +: 8] <= r_wdata[r_head][8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_sram_like_slave.sv
// Directed bench for data_sram_like_slave: cycle-exact handshake, latency,
// backpressure, reset-drop and aliasing checks with hand-computed values.
module tb_data_sram_like_slave;

    logic        clk = 1'b0;
    logic        resetn;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        stall;
    logic        data_addr_ok;
    logic [31:0] data_rdata;
    logic        data_data_ok;

    logic        c_aok;
    logic        c_dok;
    logic [31:0] c_rd;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    data_sram_like_slave #(.ADDR_W(10), .LATENCY(2), .DEPTH(2)) u_dut (
        .clk          (clk),
        .resetn       (resetn),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .stall        (stall),
        .data_addr_ok (data_addr_ok),
        .data_rdata   (data_rdata),
        .data_data_ok (data_data_ok)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive just after the edge, sample at the falling edge.
    task automatic step(input logic req, input logic wr, input logic [3:0] strb,
                        input logic [31:0] addr, input logic [31:0] wdata);
        data_req   = req;
        data_wr    = wr;
        data_size  = 2'd2;
        data_wstrb = strb;
        data_addr  = addr;
        data_wdata = wdata;
        @(negedge clk);
        c_aok = data_addr_ok;
        c_dok = data_data_ok;
        c_rd  = data_rdata;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic xact(input string tag, input logic wr, input logic [3:0] strb,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd);
        int n;
        n = 0;
        do begin
            step(1'b1, wr, strb, addr, wdata);
            n++;
        end while (!c_aok && n < 20);
        chk({tag, "_aok"}, {31'b0, c_aok}, 32'd1);
        n = 0;
        do begin
            idle();
            n++;
        end while (!c_dok && n < 20);
        chk({tag, "_dok"}, {31'b0, c_dok}, 32'd1);
        chk({tag, "_rd"}, c_rd, exp_rd);
    endtask

    logic [31:0] t3_addr   [4] = '{32'h0C, 32'h00, 32'h00, 32'h0C};
    logic [31:0] t3_rd     [4] = '{32'h1122AB44, 32'hCAFEF00D, 32'hCAFEF00D, 32'h1122AB44};
    logic        t3_aok    [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic        t3_dok    [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        int idx;
        int k;
        logic req;
        resetn = 1'b0;
        stall  = 1'b0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0;
        data_wstrb = 4'h0; data_addr = '0; data_wdata = '0;
        @(posedge clk);
        #1;

        // Reset: outputs gated low even with a request presented.
        step(1'b1, 1'b0, 4'h0, 32'h0C, 32'h0);
        chk("rst_aok", {31'b0, c_aok}, 32'd0);
        chk("rst_dok", {31'b0, c_dok}, 32'd0);
        chk("rst_rd", c_rd, 32'h0);
        idle();
        resetn = 1'b1;

        // Test 1: preload word 3, then cycle-exact load latency.
        xact("t1_pre", 1'b1, 4'hF, 32'h0C, 32'h11223344, 32'h0);
        step(1'b1, 1'b0, 4'h0, 32'h0C, 32'h0);
        chk("t1_c0_aok", {31'b0, c_aok}, 32'd1);
        chk("t1_c0_dok", {31'b0, c_dok}, 32'd0);
        idle();
        chk("t1_c1_dok", {31'b0, c_dok}, 32'd0);
        chk("t1_c1_rd", c_rd, 32'h0);
        idle();
        chk("t1_c2_dok", {31'b0, c_dok}, 32'd1);
        chk("t1_c2_rd", c_rd, 32'h11223344);

        // Test 2: byte store then load behind it (RAW), back-to-back completions.
        step(1'b1, 1'b1, 4'b0010, 32'h0D, 32'h0000AB00);
        chk("t2_c0_aok", {31'b0, c_aok}, 32'd1);
        step(1'b1, 1'b0, 4'h0, 32'h0C, 32'h0);
        chk("t2_c1_aok", {31'b0, c_aok}, 32'd1);
        chk("t2_c1_dok", {31'b0, c_dok}, 32'd0);
        idle();
        chk("t2_c2_dok", {31'b0, c_dok}, 32'd1);
        chk("t2_c2_rd", c_rd, 32'h0);
        idle();
        chk("t2_c3_dok", {31'b0, c_dok}, 32'd1);
        chk("t2_c3_rd", c_rd, 32'h1122AB44);
        idle();
        chk("t2_c4_dok", {31'b0, c_dok}, 32'd0);

        // Test 6: 0x1000 aliases 0x0000; low address bits ignored.
        xact("t6_sw", 1'b1, 4'hF, 32'h0000_1000, 32'hCAFEF00D, 32'h0);
        xact("t6_lw", 1'b0, 4'h0, 32'h0000_0000, 32'h0, 32'hCAFEF00D);
        xact("t6_lw3", 1'b0, 4'h0, 32'h0000_1003, 32'h0, 32'hCAFEF00D);

        // Test 3: request held across 4 loads with a 2-deep queue.
        idx = 0;
        k   = 0;
        for (int c = 0; c < 7; c++) begin
            req = (idx < 4);
            step(req, 1'b0, 4'h0, req ? t3_addr[idx] : 32'h0, 32'h0);
            if (c < 5) chk($sformatf("t3_c%0d_aok", c), {31'b0, c_aok}, {31'b0, t3_aok[c]});
            chk($sformatf("t3_c%0d_dok", c), {31'b0, c_dok}, {31'b0, t3_dok[c]});
            if (c_dok && k < 4) begin
                chk($sformatf("t3_rd%0d", k), c_rd, t3_rd[k]);
                k++;
            end else begin
                chk($sformatf("t3_c%0d_rd0", c), c_rd, 32'h0);
            end
            if (req && c_aok) idx++;
        end
        chk("t3_naccept", idx, 32'd4);
        chk("t3_ndok", k, 32'd4);

        // Test 4: stall holds a ready head and blocks accepts.
        step(1'b1, 1'b0, 4'h0, 32'h0C, 32'h0);
        chk("t4_c0_aok", {31'b0, c_aok}, 32'd1);
        stall = 1'b1;
        for (int c = 1; c < 4; c++) begin
            idle();
            chk($sformatf("t4_c%0d_aok", c), {31'b0, c_aok}, 32'd0);
            chk($sformatf("t4_c%0d_dok", c), {31'b0, c_dok}, 32'd0);
        end
        stall = 1'b0;
        idle();
        chk("t4_rel_dok", {31'b0, c_dok}, 32'd1);
        chk("t4_rel_rd", c_rd, 32'h1122AB44);

        // Test 5: reset drops two outstanding stores.
        step(1'b1, 1'b1, 4'hF, 32'h0C, 32'hDEADBEEF);
        chk("t5_c0_aok", {31'b0, c_aok}, 32'd1);
        step(1'b1, 1'b1, 4'hF, 32'h00, 32'h0BADF00D);
        chk("t5_c1_aok", {31'b0, c_aok}, 32'd1);
        resetn = 1'b0;
        for (int c = 2; c < 4; c++) begin
            idle();
            chk($sformatf("t5_c%0d_dok", c), {31'b0, c_dok}, 32'd0);
            chk($sformatf("t5_c%0d_aok", c), {31'b0, c_aok}, 32'd0);
        end
        resetn = 1'b1;
        idle();
        chk("t5_rel_aok", {31'b0, c_aok}, 32'd1);
        chk("t5_rel_dok", {31'b0, c_dok}, 32'd0);
        idle();
        chk("t5_rel2_dok", {31'b0, c_dok}, 32'd0);
        xact("t5_w3", 1'b0, 4'h0, 32'h0C, 32'h0, 32'h1122AB44);
        xact("t5_w0", 1'b0, 4'h0, 32'h00, 32'h0, 32'hCAFEF00D);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
